// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin front end sharing one serial GCD engine among
// N_REQ requesters; optional WAIT watchdog under GCD_SCHED_TIMEOUT_EN.
// Ports: clk, rst (sync, active-high); req_valid/req_a/req_b in, req_ready out;
// rsp_valid/rsp_data/rsp_err/busy out; gcd_start/gcd_in out, gcd_out/gcd_done in.
module gcd_scheduler #(
  parameter int N_REQ          = 4,
  parameter int W              = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               gcd_start,
  output logic [W-1:0]       gcd_in,
  input  logic [W-1:0]       gcd_out,
  input  logic               gcd_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     own_q;
  logic [W-1:0]      b_q;
  logic [N_REQ-1:0]  rspv_q;
  logic [W-1:0]      data_q;
  logic              busy_q;
  logic              start_q;
  logic [W-1:0]      in_q;

  logic [IW-1:0]     grant_d;
  logic [IW-1:0]     idx_d;
  logic              found_d;
  logic              accept_d;
  logic [W-1:0]      a_d;
  logic [W-1:0]      b_d;

  // Scan upward from the slot after the last grant, wrapping.
  always_comb begin
    grant_d = last_q;
    found_d = 1'b0;
    idx_d   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_d = IW'((int'(last_q) + k) % N_REQ);
      if (!found_d && req_valid[idx_d]) begin
        grant_d = idx_d;
        found_d = 1'b1;
      end
    end
  end

  assign accept_d  = (state_q == S_IDLE) && found_d;
  assign req_ready = accept_d ? (N_REQ'(1) << grant_d) : '0;
  assign a_d       = req_a[int'(grant_d)*W +: W];
  assign b_d       = req_b[int'(grant_d)*W +: W];

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign rsp_err = err_q;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ - 1);
      own_q   <= '0;
      b_q     <= '0;
      rspv_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      in_q    <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            last_q <= grant_d;
            own_q  <= grant_d;
            b_q    <= b_d;
            busy_q <= 1'b1;
            // A zero operand needs no engine: gcd(x,0)=x.
            if (a_d == '0 || b_d == '0) begin
              state_q <= S_RESP;
              rspv_q  <= N_REQ'(1) << grant_d;
              data_q  <= a_d | b_d;
            end else begin
              state_q <= S_LOAD_A;
              start_q <= 1'b1;
              in_q    <= a_d;
            end
          end
        end
        S_LOAD_A: begin
          state_q <= S_LOAD_B;
          start_q <= 1'b0;
          in_q    <= b_q;
        end
        S_LOAD_B: begin
          state_q <= S_WAIT;
`ifdef GCD_SCHED_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          if (gcd_done) begin
            state_q <= S_RESP;
            rspv_q  <= N_REQ'(1) << own_q;
            data_q  <= gcd_out;
            in_q    <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_RESP;
            rspv_q  <= N_REQ'(1) << own_q;
            data_q  <= '0;
            err_q   <= 1'b1;
            in_q    <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
`endif
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          rspv_q  <= '0;
          data_q  <= '0;
          busy_q  <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rspv_q;
  assign rsp_data  = data_q;
  assign busy      = busy_q;
  assign gcd_start = start_q;
  assign gcd_in    = in_q;

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one GCD engine among `N_REQ` requesters. It accepts one operand pair at a time and feeds the engine's serial operand port: `Start` with A, then B on the next cycle. It captures the engine result on `Done` and returns it to the owning requester. It sits between the requester clients and the single `GCD` instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 16: operand/result width; matches the engine `In`/`Out` width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in WAIT. Used only with the macro.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester job request; held until accepted.
- `req_a`  in  N_REQ*W  packed operand A; slice i belongs to requester i.
- `req_b`  in  N_REQ*W  packed operand B.
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle result pulse to the owner.
- `rsp_data`  out  W  result; valid only while `rsp_valid` is nonzero.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `gcd_start`  out  1  drives the engine `Start`.
- `gcd_in`  out  W  drives the engine `In`.
- `gcd_out`  in  W  engine `Out`.
- `gcd_done`  in  1  engine `Done`.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - If any `req_valid` bit is set, pick the winner: search upward from `last_grant+1`, wrapping modulo N_REQ.
  - Pulse `req_ready[winner]` and latch the winner's A, B and index. Set `last_grant` to the winner.
  - If A==0 or B==0, go to RESP with result = A|B, so gcd(x,0)=x and gcd(0,0)=0. Otherwise go to LOAD_A.
- LOAD_A: `gcd_start`=1, `gcd_in`=A. Go to LOAD_B.
- LOAD_B: `gcd_start`=0, `gcd_in`=B. Go to WAIT.
- WAIT:
  - `gcd_in` is held at B.
  - On the first cycle with `gcd_done`=1, latch `gcd_out` and go to RESP.
  - `gcd_done` is ignored in every other state, including stale Done high during LOAD_A/LOAD_B.
- RESP: `rsp_valid[owner]`=1 and `rsp_data`=latched result for exactly one cycle. Go to IDLE.
- No new request is accepted before RESP completes. Requests that are not granted simply keep waiting.
- A requester dropping `req_valid` before it is granted is legal; it is never granted.
- `gcd_in`=0 in IDLE and RESP.

## Timing
- Reset (synchronous, one cycle):
  - FSM goes to IDLE.
  - `last_grant` resets to N_REQ-1, so requester 0 has first priority.
  - All outputs are 0 on the cycle after `rst` is sampled high.
- Reset mid-job: the job is dropped, no `rsp_valid` is issued, and the engine is reset by the same `rst`.
- Normal job, with accept at cycle 0:
  - `gcd_start` is high in cycle 1.
  - B is presented in cycle 2.
  - WAIT begins in cycle 3.
  - If Done is seen in cycle k, RESP occurs in cycle k+1.
- Bypass job (zero operand): accept at cycle 0, RESP at cycle 1, and `gcd_start` is never asserted.
- Minimum spacing between accepts is 2 cycles (bypass path). The next accept can occur in the IDLE cycle right after RESP.
- `req_ready` is combinational from IDLE state and `req_valid`. All other outputs are registered or state-decoded.

## Configuration
- `GCD_SCHED_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no Done, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A Done that arrives in the same cycle as the limit takes priority and gives a normal response.
- `GCD_SCHED_TIMEOUT_EN` undefined:
  - No counter exists, and WAIT waits indefinitely.
  - The `rsp_err` port still exists and is tied to 0.

## Test plan
- Single job: req0, A=12, B=18.
  - `req_ready[0]` pulses in cycle 0.
  - Cycle 1: `gcd_start`=1, `gcd_in`=12. Cycle 2: `gcd_in`=18.
  - `rsp_valid[0]` with `rsp_data`=6 one cycle after `gcd_done`.
- Arbitration: after reset, req1 (A=9, B=6) and req2 (A=35, B=14) are raised together.
  - req1 is served first (3), then req2 (7).
  - Then req0, req1 and req2 are raised together: the order is req0, req1, req2.
- Zero bypass: req3 with A=0, B=9 gives rsp 9 at cycle 1. A=0, B=0 gives rsp 0. `gcd_start` stays 0 throughout.
- Stale Done: the engine model holds `gcd_done`=1 during LOAD_A/LOAD_B. It must be ignored, and the result is taken only from WAIT.
- Reset mid-WAIT: `rst` pulsed during WAIT of a 100/75 job.
  - Outputs go to 0 next cycle and `busy`=0.
  - No `rsp_valid` is issued.
  - The next request is served starting from requester 0 priority.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): the engine model never asserts Done.
  - After 8 WAIT cycles: `rsp_valid[owner]`, `rsp_err`=1, `rsp_data`=0.
  - Repeated with the macro off: no response within 100 cycles and `busy` stays high.
